// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM-stage access controller.
//   state_t        FSM encoding (IDLE=0, BUSY=1)
//   DATA_W_DEF     default data/address width
//   REG_W_DEF      default register-index width
//   WB_BUBBLE_BIT  fill value for every MEM/WB field when a bubble is retired
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W_DEF  = 5;

    // A bubble is all MEM/WB fields zero; the top replicates this bit
    // across its parameter-sized MEM/WB record.
    localparam logic WB_BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/mem_busy_timer.sv
// mem_busy_timer: clear/enable up-counter with terminal-count flag.
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   i_clr  synchronous clear to 0 (wins over i_en)
//   i_en   count enable; the count holds once it reaches TC-1
//   o_tc   high while count == TC-1
module mem_busy_timer #(
    parameter int unsigned TC = 16    // terminal count + 1, must be >= 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned CW = $clog2(TC);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == CW'(TC - 1));
    assign o_tc = w_tc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage access controller and MEM/WB pipeline register.
// Optional build macro: MEM_ALIGN_CHECK_EN (misaligned accesses retire as a
// bubble without a memory request and raise MemErr the following cycle).
//   clk, reset                 clock / async active-high reset
//   Address, WriteDataMEM,     EX/MEM data inputs
//   WriteRegMEM
//   RegWriteMEM, MemReadMEM,   EX/MEM control inputs
//   MemWriteMEM, MemtoRegMEM
//   mem_req/mem_we/mem_addr/   request/acknowledge data-memory port
//   mem_wdata, mem_ack, mem_rdata
//   Stall                      freezes PC, IF/ID, ID/EX, EX/MEM
//   ReadDataWB, ALUResultWB,   MEM/WB register outputs
//   WriteRegWB, RegWriteWB, MemtoRegWB
//   MemErr                     one-cycle error pulse (timeout / misalign)
module mem_access_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned REG_W       = REG_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteDataMEM,
    input  logic [REG_W-1:0]  WriteRegMEM,
    input  logic              RegWriteMEM,
    input  logic              MemReadMEM,
    input  logic              MemWriteMEM,
    input  logic              MemtoRegMEM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              Stall,
    output logic [DATA_W-1:0] ReadDataWB,
    output logic [DATA_W-1:0] ALUResultWB,
    output logic [REG_W-1:0]  WriteRegWB,
    output logic              RegWriteWB,
    output logic              MemtoRegWB,
    output logic              MemErr
);

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  wreg;
        logic              regwrite;
        logic              memtoreg;
    } mem_wb_t;

    localparam mem_wb_t WB_BUBBLE = mem_wb_t'({$bits(mem_wb_t){WB_BUBBLE_BIT}});

    state_t              r_state;
    mem_wb_t             r_wb;
    logic [REG_W-1:0]    r_wreg;
    logic                r_regwrite;
    logic                r_memtoreg;

    logic                w_access;
    logic                w_misalign;
    logic                w_start;
    logic                w_tc;
    logic                w_timeout;

    assign w_access = MemReadMEM | MemWriteMEM;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_access & (Address[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start   = w_access & ~w_misalign;
    // An ack on the terminal-count cycle still completes the access.
    assign w_timeout = (r_state == BUSY) & w_tc & ~mem_ack;

    // Combinational so the detect cycle already freezes upstream; gated by
    // reset so the stall drops immediately on an asynchronous reset.
    assign Stall = ~reset & ((r_state == IDLE) ? w_start : (~mem_ack & ~w_timeout));

    mem_busy_timer #(
        .TC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk (clk),
        .i_rst (reset),
        .i_clr ((r_state == IDLE) & w_start),
        .i_en  (r_state == BUSY),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            r_wreg     <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_wb       <= WB_BUBBLE;
            MemErr     <= 1'b0;
        end else begin
            MemErr <= 1'b0;
            r_wb   <= WB_BUBBLE;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        mem_req    <= 1'b1;
                        mem_we     <= MemWriteMEM;
                        mem_addr   <= Address;
                        mem_wdata  <= WriteDataMEM;
                        r_wreg     <= WriteRegMEM;
                        r_regwrite <= RegWriteMEM;
                        r_memtoreg <= MemtoRegMEM;
                        r_state    <= BUSY;
                    end else if (w_misalign) begin
                        MemErr <= 1'b1;
                    end else begin
                        r_wb <= '{rdata:    '0,
                                  alu:      Address,
                                  wreg:     WriteRegMEM,
                                  regwrite: RegWriteMEM,
                                  memtoreg: MemtoRegMEM};
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        r_wb <= '{rdata:    mem_we ? '0 : mem_rdata,
                                  alu:      mem_addr,
                                  wreg:     r_wreg,
                                  regwrite: r_regwrite,
                                  memtoreg: r_memtoreg};
                        mem_req <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        MemErr  <= 1'b1;
                        mem_req <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ReadDataWB  = r_wb.rdata;
    assign ALUResultWB = r_wb.alu;
    assign WriteRegWB  = r_wb.wreg;
    assign RegWriteWB  = r_wb.regwrite;
    assign MemtoRegWB  = r_wb.memtoreg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven bench with a WB scoreboard for mem_access_ctrl.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteDataMEM;
    logic [4:0]  WriteRegMEM;
    logic        RegWriteMEM;
    logic        MemReadMEM;
    logic        MemWriteMEM;
    logic        MemtoRegMEM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        Stall;
    logic [31:0] ReadDataWB;
    logic [31:0] ALUResultWB;
    logic [4:0]  WriteRegWB;
    logic        RegWriteWB;
    logic        MemtoRegWB;
    logic        MemErr;

    mem_access_ctrl #(
        .DATA_W      (32),
        .REG_W       (5),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Address      (Address),
        .WriteDataMEM (WriteDataMEM),
        .WriteRegMEM  (WriteRegMEM),
        .RegWriteMEM  (RegWriteMEM),
        .MemReadMEM   (MemReadMEM),
        .MemWriteMEM  (MemWriteMEM),
        .MemtoRegMEM  (MemtoRegMEM),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .Stall        (Stall),
        .ReadDataWB   (ReadDataWB),
        .ALUResultWB  (ALUResultWB),
        .WriteRegWB   (WriteRegWB),
        .RegWriteWB   (RegWriteWB),
        .MemtoRegWB   (MemtoRegWB),
        .MemErr       (MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  wreg;
        logic        rw;
        logic        m2r;
        int unsigned delay;   // BUSY cycles before the ack cycle
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        rw;
        logic        m2r;
    } wb_t;

    int   n_checks;
    int   n_fail;
    wb_t  exp_q[$];
    wb_t  mon_e;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every non-bubble MEM/WB entry must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && (RegWriteWB || MemtoRegWB || ALUResultWB != 32'h0 ||
                       WriteRegWB != 5'h0 || ReadDataWB != 32'h0)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wb: got alu=0x%0h rdata=0x%0h, required no entry",
                         ALUResultWB, ReadDataWB);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rdata",    ReadDataWB,         mon_e.rdata);
                chk("wb_alu",      ALUResultWB,        mon_e.alu);
                chk("wb_wreg",     32'(WriteRegWB),    32'(mon_e.wreg));
                chk("wb_regwrite", 32'(RegWriteWB),    32'(mon_e.rw));
                chk("wb_memtoreg", 32'(MemtoRegWB),    32'(mon_e.m2r));
            end
        end
    end

    task automatic drive_idle();
        Address      = 32'h0;
        WriteDataMEM = 32'h0;
        WriteRegMEM  = 5'h0;
        RegWriteMEM  = 1'b0;
        MemReadMEM   = 1'b0;
        MemWriteMEM  = 1'b0;
        MemtoRegMEM  = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge on which
    // the instruction leaves MEM.
    task automatic apply_vec(input vec_t v);
        wb_t         e;
        int unsigned stalls;
        logic        is_mem;
        is_mem       = v.rd | v.wr;
        Address      = v.addr;
        WriteDataMEM = v.wdata;
        WriteRegMEM  = v.wreg;
        RegWriteMEM  = v.rw;
        MemReadMEM   = v.rd;
        MemWriteMEM  = v.wr;
        MemtoRegMEM  = v.m2r;
        e.rdata = (v.rd && !v.wr) ? v.rdata : 32'h0;
        e.alu   = v.addr;
        e.wreg  = v.wreg;
        e.rw    = v.rw;
        e.m2r   = v.m2r;
        exp_q.push_back(e);
        stalls = 0;
        @(negedge clk);
        chk("req_idle", 32'(mem_req), 32'd0);
        if (Stall) stalls++;
        if (is_mem) begin
            for (int unsigned k = 0; k <= v.delay; k++) begin
                @(posedge clk); #1;
                if (k == v.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end else begin
                    mem_rdata = ~v.rdata;
                end
                @(negedge clk);
                chk("req_busy",   32'(mem_req), 32'd1);
                chk("addr_busy",  mem_addr,     v.addr);
                chk("we_busy",    32'(mem_we),  32'(v.wr));
                chk("wdata_busy", mem_wdata,    v.wdata);
                if (Stall) stalls++;
            end
        end
        chk("stall_cycles", stalls, is_mem ? 32'(1 + v.delay) : 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [4:0] wreg, input logic rw, input logic m2r,
                                input int unsigned delay);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.wreg = wreg; v.rw = rw; v.m2r = m2r; v.delay = delay;
        return v;
    endfunction

    initial begin
        int unsigned n;
        logic        done;
        n_checks  = 0;
        n_fail    = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        drive_idle();
        reset = 1'b0;

        //        rd  wr   addr          wdata         rdata         wreg  rw  m2r delay
        tbl.push_back(mk(0, 0, 32'h0000_0010, 32'h0,        32'h0,        5'd5,  1, 0, 0));
        tbl.push_back(mk(0, 0, 32'hABCD_0000, 32'h0,        32'h0,        5'd31, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0040, 32'h0,        32'hDEAD_BEEF, 5'd8, 1, 1, 3));
        tbl.push_back(mk(0, 1, 32'h0000_0080, 32'h0000_1234, 32'h0,       5'd0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0000_0044, 32'h0,        32'h0BAD_F00D, 5'd9, 1, 1, 0));
        tbl.push_back(mk(1, 1, 32'h0000_0090, 32'h0000_55AA, 32'hFFFF_FFFF, 5'd2, 0, 0, 1));
        tbl.push_back(mk(1, 0, 32'h0000_0048, 32'h0,        32'h1357_9BDF, 5'd3, 1, 1, 15));
        tbl.push_back(mk(0, 0, 32'h7FFF_FFFC, 32'h0,        32'h0,        5'd1,  0, 0, 0));
`ifndef MEM_ALIGN_CHECK_EN
        tbl.push_back(mk(1, 0, 32'h0000_0042, 32'h0,        32'h2468_ACE0, 5'd6, 1, 1, 2));
`endif

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk("rst_mem_req",     32'(mem_req),    32'd0);
        chk("rst_mem_we",      32'(mem_we),     32'd0);
        chk("rst_mem_addr",    mem_addr,        32'd0);
        chk("rst_mem_wdata",   mem_wdata,       32'd0);
        chk("rst_stall",       32'(Stall),      32'd0);
        chk("rst_readdata",    ReadDataWB,      32'd0);
        chk("rst_aluresult",   ALUResultWB,     32'd0);
        chk("rst_writereg",    32'(WriteRegWB), 32'd0);
        chk("rst_regwrite",    32'(RegWriteWB), 32'd0);
        chk("rst_memtoreg",    32'(MemtoRegWB), 32'd0);
        chk("rst_memerr",      32'(MemErr),     32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);
        drive_idle();
        repeat (3) @(posedge clk);
        #1;

        // Timeout: load never acknowledged
        Address = 32'h0000_0100; WriteRegMEM = 5'd7; RegWriteMEM = 1'b1;
        MemReadMEM = 1'b1; MemtoRegMEM = 1'b1;
        @(negedge clk);
        chk("to_detect_stall", 32'(Stall), 32'd1);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
            chk("to_memerr_busy", 32'(MemErr), 32'd0);
            if (!Stall) done = 1'b1;
        end
        chk("to_busy_cycles", n, 32'd16);
        chk("to_req_last", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("to_memerr",   32'(MemErr),  32'd1);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_stall",    32'(Stall),   32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_memerr_once", 32'(MemErr), 32'd0);

        // Asynchronous reset during BUSY, then a stray ack
        @(posedge clk); #1;
        Address = 32'h0000_0200; WriteRegMEM = 5'd4; RegWriteMEM = 1'b1;
        MemReadMEM = 1'b1; MemtoRegMEM = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_req_pre",   32'(mem_req), 32'd1);
        chk("rb_stall_pre", 32'(Stall),   32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rb_req_async",   32'(mem_req), 32'd0);
        chk("rb_stall_async", 32'(Stall),   32'd0);
        drive_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("stray_req",   32'(mem_req), 32'd0);
        chk("stray_stall", 32'(Stall),   32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_readdata", ReadDataWB,      32'd0);
        chk("stray_regwrite", 32'(RegWriteWB), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned load: no request, no stall, error next cycle
        @(posedge clk); #1;
        Address = 32'h0000_0042; WriteRegMEM = 5'd6; RegWriteMEM = 1'b1;
        MemReadMEM = 1'b1; MemtoRegMEM = 1'b1;
        @(negedge clk);
        chk("mis_stall", 32'(Stall),   32'd0);
        chk("mis_req",   32'(mem_req), 32'd0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("mis_memerr", 32'(MemErr),  32'd1);
        chk("mis_req2",   32'(mem_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_memerr_once", 32'(MemErr), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
